// File: rtl/xc_aessub_pkg.sv
// Shared types and elaboration helpers for the AES SubBytes sequencer.
// The XC_AESSUB_SEQ_PARALLEL_EN build option is handled in xc_aessub_seq.
package xc_aessub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int BYTE_W = 8;

  function automatic bit nbytes_ok(input int n);
    return (n == 4) || (n == 8);
  endfunction

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/xc_aessub_bytelane.sv
// One S-box lane: picks byte idx of src, substitutes it, and presents it as a
// positioned write with a byte enable for the result register.
module xc_aessub_bytelane
  import xc_aessub_pkg::*;
#(
  parameter int NBYTES = 4,
  parameter int IW     = 2
) (
  input  logic [BYTE_W*NBYTES-1:0] src,
  input  logic [IW-1:0]            idx,
  input  logic                     dec,
  input  logic                     en,
  output logic [BYTE_W*NBYTES-1:0] wr_data,
  output logic [NBYTES-1:0]        wr_be
);

  localparam int W = BYTE_W * NBYTES;

  logic [BYTE_W-1:0] byte_in;
  logic [BYTE_W-1:0] byte_out;

  assign byte_in = src[BYTE_W*idx +: BYTE_W];

  xc_aessub_sbox u_sbox (
    .dec  (dec),
    .din  (byte_in),
    .dout (byte_out)
  );

  assign wr_data = W'(byte_out) << (BYTE_W * idx);
  assign wr_be   = en ? (NBYTES'(1) << idx) : '0;

endmodule

// File: rtl/xc_aessub_sbox.sv
// Combinational AES S-box, forward or inverse, sharing one GF(2^8) inversion.
module xc_aessub_sbox (
  input  logic       dec,
  input  logic [7:0] din,
  output logic [7:0] dout
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse, and maps 0 to 0 as the S-box needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gf_mul(a, a);
    x3   = gf_mul(x2, a);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    return gf_mul(x252, x2);
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  logic [7:0] inv_aff;
  logic [7:0] inv_in;
  logic [7:0] inv_out;
  logic [7:0] fwd_aff;

  assign inv_aff = rotl(din, 1) ^ rotl(din, 3) ^ rotl(din, 6) ^ 8'h05;
  assign inv_in  = dec ? inv_aff : din;
  assign inv_out = gf_inv(inv_in);
  assign fwd_aff = inv_out ^ rotl(inv_out, 1) ^ rotl(inv_out, 2) ^ rotl(inv_out, 3)
                 ^ rotl(inv_out, 4) ^ 8'h63;
  assign dout    = dec ? inv_out : fwd_aff;

endmodule

// File: rtl/xc_aessub_seq.sv
// AES SubBytes sequencer: byte-serial through one S-box by default; defining
// XC_AESSUB_SEQ_PARALLEL_EN instantiates NBYTES lanes and finishes in one BUSY cycle.
module xc_aessub_seq
  import xc_aessub_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                    g_clk,
  input  logic                    g_resetn,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_dec,
  input  logic [8*NBYTES-1:0]     in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [8*NBYTES-1:0]     out_data
);

  localparam int W  = BYTE_W * NBYTES;
  localparam int IW = idx_w(NBYTES);

  if (!nbytes_ok(NBYTES)) begin : g_bad_nbytes
    $error("xc_aessub_seq: NBYTES must be 4 or 8");
  end

  state_t         state, state_nxt;
  logic [W-1:0]   src;
  logic           dec;
  logic           accept;
  logic           last;
  logic           lane_en;
  logic [W-1:0]   wr_data;
  logic [NBYTES-1:0] wr_be;
  logic [W-1:0]   wr_mask;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready && !flush;
  assign lane_en   = (state == BUSY) && !flush;

`ifdef XC_AESSUB_SEQ_PARALLEL_EN
  logic [W-1:0]      lane_data [NBYTES];
  logic [NBYTES-1:0] lane_be   [NBYTES];

  assign last = 1'b1;

  for (genvar i = 0; i < NBYTES; i++) begin : g_lane
    xc_aessub_bytelane #(.NBYTES(NBYTES), .IW(IW)) u_lane (
      .src     (src),
      .idx     (IW'(i)),
      .dec     (dec),
      .en      (lane_en),
      .wr_data (lane_data[i]),
      .wr_be   (lane_be[i])
    );
  end

  always_comb begin
    wr_data = '0;
    wr_be   = '0;
    for (int i = 0; i < NBYTES; i++) begin
      wr_data = wr_data | lane_data[i];
      wr_be   = wr_be | lane_be[i];
    end
  end
`else
  logic [IW-1:0] idx;

  assign last = (idx == IW'(NBYTES - 1));

  xc_aessub_bytelane #(.NBYTES(NBYTES), .IW(IW)) u_lane (
    .src     (src),
    .idx     (idx),
    .dec     (dec),
    .en      (lane_en),
    .wr_data (wr_data),
    .wr_be   (wr_be)
  );

  // idx stops at the last byte rather than wrapping, so DONE never sees a stale index.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      idx <= '0;
    end else if (accept || flush) begin
      idx <= '0;
    end else if (lane_en && !last) begin
      idx <= idx + IW'(1);
    end
  end
`endif

  always_comb begin
    wr_mask = '0;
    for (int i = 0; i < NBYTES; i++) begin
      wr_mask[BYTE_W*i +: BYTE_W] = {BYTE_W{wr_be[i]}};
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_valid) state_nxt = BUSY;
        BUSY:    if (last)     state_nxt = DONE;
        DONE:    if (out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state    <= IDLE;
      src      <= '0;
      dec      <= 1'b0;
      out_data <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        src      <= in_data;
        dec      <= in_dec;
        out_data <= '0;
      end else if (lane_en) begin
        out_data <= (out_data & ~wr_mask) | wr_data;
      end
    end
  end

endmodule

// File: tb/tb_xc_aessub_seq.sv
// Directed bench for xc_aessub_seq: a 4-byte instance for handshake/flush/reset
// scenarios and an 8-byte instance swept over every byte value in both directions.
module tb_xc_aessub_seq;

`ifdef XC_AESSUB_SEQ_PARALLEL_EN
  localparam int LAT4 = 1;
  localparam int LAT8 = 1;
`else
  localparam int LAT4 = 4;
  localparam int LAT8 = 8;
`endif

  logic        g_clk = 1'b0;
  logic        g_resetn = 1'b0;
  logic        flush = 1'b0;

  logic        iv4 = 1'b0, ir4, dec4 = 1'b0, ov4, ordy4 = 1'b0;
  logic [31:0] id4 = '0, od4;
  logic        iv8 = 1'b0, ir8, dec8 = 1'b0, ov8, ordy8 = 1'b0;
  logic [63:0] id8 = '0, od8;

  int checks = 0;
  int failures = 0;

  logic [7:0] sbox_fwd [0:255] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  xc_aessub_seq #(.NBYTES(4)) u_dut4 (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .flush     (flush),
    .in_valid  (iv4),
    .in_ready  (ir4),
    .in_dec    (dec4),
    .in_data   (id4),
    .out_valid (ov4),
    .out_ready (ordy4),
    .out_data  (od4)
  );

  xc_aessub_seq #(.NBYTES(8)) u_dut8 (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .flush     (flush),
    .in_valid  (iv8),
    .in_ready  (ir8),
    .in_dec    (dec8),
    .in_data   (id8),
    .out_valid (ov8),
    .out_ready (ordy8),
    .out_data  (od8)
  );

  always #5 g_clk = ~g_clk;

  task automatic step();
    @(posedge g_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request from IDLE, scramble the inputs while the op runs, and
  // return the edge count until out_valid (0 if it never came) and the result.
  task automatic req(input bit wide, input logic [63:0] d, input logic dir,
                     output int lat, output logic [63:0] res);
    if (wide) begin iv8 = 1'b1; id8 = d; dec8 = dir; end
    else      begin iv4 = 1'b1; id4 = d[31:0]; dec4 = dir; end
    step();
    iv4 = 1'b0; iv8 = 1'b0;
    id4 = ~id4; dec4 = ~dec4; id8 = ~id8; dec8 = ~dec8;
    lat = 0;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      step();
      if (wide ? ov8 : ov4) lat = n;
    end
    res = wide ? od8 : {32'h0, od4};
  endtask

  task automatic rel(input bit wide);
    if (wide) ordy8 = 1'b1; else ordy4 = 1'b1;
    step();
    ordy4 = 1'b0; ordy8 = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [63:0] res;
    logic [63:0] d, e;
    logic [7:0]  sbox_inv [0:255];
    logic        seen;

    for (int i = 0; i < 256; i++) sbox_inv[sbox_fwd[i]] = 8'(i);

    step(); step();
    chk("rst_in_ready4", {63'h0, ir4}, 64'h1);
    chk("rst_out_valid4", {63'h0, ov4}, 64'h0);
    chk("rst_out_data4", {32'h0, od4}, 64'h0);
    chk("rst_in_ready8", {63'h0, ir8}, 64'h1);
    chk("rst_out_data8", od8, 64'h0);
    g_resetn = 1'b1;
    step();

    // forward
    req(1'b0, 64'h53020100, 1'b0, lat, res);
    chk("fwd_lat", 64'(lat), 64'(LAT4));
    chk("fwd_data", res, 64'hed777c63);
    rel(1'b0);
    chk("fwd_rel_valid", {63'h0, ov4}, 64'h0);
    chk("fwd_rel_ready", {63'h0, ir4}, 64'h1);

    // inverse, with inputs scrambled during BUSY inside req
    req(1'b0, 64'hed777c63, 1'b1, lat, res);
    chk("inv_lat", 64'(lat), 64'(LAT4));
    chk("inv_data", res, 64'h53020100);
    rel(1'b0);

    // backpressure, with a competing request held during DONE
    req(1'b0, 64'h0a0b0c0d, 1'b0, lat, res);
    chk("bp_data", res, 64'h672bfed7);
    iv4 = 1'b1; id4 = 32'h11111111; dec4 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", {63'h0, ov4}, 64'h1);
      chk("bp_hold", {32'h0, od4}, 64'h672bfed7);
      chk("bp_ready", {63'h0, ir4}, 64'h0);
    end
    iv4 = 1'b0;
    rel(1'b0);
    chk("bp_rel_valid", {63'h0, ov4}, 64'h0);
    chk("bp_rel_ready", {63'h0, ir4}, 64'h1);
    chk("bp_retain", {32'h0, od4}, 64'h672bfed7);

    // flush mid-op with in_valid held, then flush in IDLE with in_valid
    iv4 = 1'b1; id4 = 32'h44444444; dec4 = 1'b0;
    step();
`ifndef XC_AESSUB_SEQ_PARALLEL_EN
    step(); step();
`endif
    flush = 1'b1;
    step();
    chk("flush_idle", {63'h0, ir4}, 64'h1);
    chk("flush_valid", {63'h0, ov4}, 64'h0);
    step();
    chk("flush_no_accept", {63'h0, ir4}, 64'h1);
    flush = 1'b0; iv4 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (ov4) seen = 1'b1;
    end
    chk("flush_never_valid", {63'h0, seen}, 64'h0);
    req(1'b0, 64'h11111111, 1'b0, lat, res);
    chk("post_flush_lat", 64'(lat), 64'(LAT4));
    chk("post_flush_data", res, 64'h82828282);
    rel(1'b0);

    // reset mid-op
    iv4 = 1'b1; id4 = 32'h11111111; dec4 = 1'b0;
    step();
    iv4 = 1'b0;
    step();
    g_resetn = 1'b0;
    step();
    chk("rst_mid_valid", {63'h0, ov4}, 64'h0);
    chk("rst_mid_data", {32'h0, od4}, 64'h0);
    chk("rst_mid_ready", {63'h0, ir4}, 64'h1);
    g_resetn = 1'b1;
    step();

    // 8-byte sweep over every byte value, both directions
    for (int j = 0; j < 32; j++) begin
      for (int b = 0; b < 8; b++) begin
        d[8*b +: 8] = 8'(8*j + b);
        e[8*b +: 8] = sbox_fwd[8*j + b];
      end
      req(1'b1, d, 1'b0, lat, res);
      chk("sweep_fwd_lat", 64'(lat), 64'(LAT8));
      chk("sweep_fwd_data", res, e);
      rel(1'b1);
    end
    for (int j = 0; j < 32; j++) begin
      for (int b = 0; b < 8; b++) begin
        d[8*b +: 8] = 8'(8*j + b);
        e[8*b +: 8] = sbox_inv[8*j + b];
      end
      req(1'b1, d, 1'b1, lat, res);
      chk("sweep_inv_lat", 64'(lat), 64'(LAT8));
      chk("sweep_inv_data", res, e);
      rel(1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
